enigma_sequencer: RTL

ENIGMA_SEQUENCER -- requirements
Module: enigma_sequencer

---
 rtl/enigma_pkg.sv | 43 ++++
 rtl/enigma_sequencer_letter_shift.sv | 23 ++
 rtl/enigma_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared constants, FSM state encoding and ROM address layout for the
// three-rotor Enigma sequencer.
package enigma_pkg;

  localparam logic [4:0] NUM_LETTERS = 5'd26;
  localparam logic [4:0] LAST_LETTER = NUM_LETTERS - 5'd1;
  localparam logic [4:0] NOTCH       = 5'd25;
  localparam logic [2:0] NUM_TYPES   = 3'd5;
  localparam logic [2:0] LAST_TYPE   = NUM_TYPES - 3'd1;

  localparam int unsigned NUM_ROTORS = 3;

  // Lookup index: 0..2 forward through rotors 0,1,2; 3..5 backward through 2,1,0.
  localparam logic [2:0] IDX_LAST_FWD = 3'd2;
  localparam logic [2:0] IDX_LAST     = 3'd5;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP    = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    REFL    = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0] rotor_type;
    logic       dir;
    logic [4:0] letter;
  } rom_addr_t;

  function automatic logic [4:0] next_letter(input logic [4:0] v);
    return (v == LAST_LETTER) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [2:0] next_type(input logic [2:0] v);
    return (v == LAST_TYPE) ? 3'd0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/enigma_sequencer_letter_shift.sv
// Combinational mod-26 offset: letter + shift, or letter - shift, using a
// 6-bit sum and a single conditional subtract of 26.
module letter_shift
  import enigma_pkg::*;
(
  input  logic [4:0] letter,
  input  logic [4:0] shift,
  input  logic       subtract,
  output logic [4:0] result
);

  logic [5:0] sum;

  always_comb begin
    if (subtract) begin
      sum = {1'b0, letter} + ({1'b0, NUM_LETTERS} - {1'b0, shift});
    end else begin
      sum = {1'b0, letter} + {1'b0, shift};
    end
    result = (sum >= {1'b0, NUM_LETTERS}) ? 5'(sum - {1'b0, NUM_LETTERS}) : sum[4:0];
  end

endmodule

// File: rtl/enigma_sequencer.sv
// Three-rotor Enigma sequencer: steps the rotors on each accepted key, then
// walks six ROM lookups and one reflector pass to produce the ciphertext.
module enigma_sequencer
  import enigma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        key_ok,
  input  logic [4:0]  key,
  input  logic        increase_shift_or_type,
  input  logic        increase0,
  input  logic        increase1,
  input  logic        increase2,
  output logic [8:0]  rom_addr,
  output logic        rom_en,
  input  logic [15:0] rom_dout,
  output logic [4:0]  refl_in,
  input  logic [4:0]  refl_out,
  output logic [4:0]  letter_out,
  output logic        out_valid,
  output logic        busy,
  output logic        key_dropped,
  output logic [4:0]  shift0,
  output logic [4:0]  shift1,
  output logic [4:0]  shift2,
  output logic [2:0]  type0,
  output logic [2:0]  type1,
  output logic [2:0]  type2
);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [4:0] cur, cur_nxt;
  logic [4:0] shift_r   [NUM_ROTORS];
  logic [4:0] shift_nxt [NUM_ROTORS];
  logic [2:0] type_r    [NUM_ROTORS];
  logic [2:0] type_nxt  [NUM_ROTORS];
  logic [4:0] letter_nxt;
  logic       out_valid_nxt;
  logic       key_dropped_nxt;
  logic [8:0] rom_addr_q;

  logic [2:0] inc_vec;
  logic       key_accept;
  logic       backward;
  logic [1:0] rotor_sel;
  logic [4:0] sel_shift;
  logic [2:0] sel_type;
  logic [4:0] entry_letter;
  logic [4:0] exit_letter;
  rom_addr_t  issue_addr;
  logic       unused_rom_bits;

  assign inc_vec         = {increase2, increase1, increase0};
  assign unused_rom_bits = ^rom_dout[15:5];

  always_comb begin
    backward  = (idx > IDX_LAST_FWD);
    rotor_sel = backward ? 2'(IDX_LAST - idx) : idx[1:0];
    case (rotor_sel)
      2'd0: begin
        sel_shift = shift_r[0];
        sel_type  = type_r[0];
      end
      2'd1: begin
        sel_shift = shift_r[1];
        sel_type  = type_r[1];
      end
      default: begin
        sel_shift = shift_r[2];
        sel_type  = type_r[2];
      end
    endcase
  end

  letter_shift u_entry (
    .letter   (cur),
    .shift    (sel_shift),
    .subtract (1'b0),
    .result   (entry_letter)
  );

  letter_shift u_exit (
    .letter   (rom_dout[4:0]),
    .shift    (sel_shift),
    .subtract (1'b1),
    .result   (exit_letter)
  );

  always_comb begin
    issue_addr.rotor_type = sel_type;
    issue_addr.dir        = backward ? DIR_BWD : DIR_FWD;
    issue_addr.letter     = entry_letter;
  end

  // Address is live only in ISSUE; otherwise the last issued address is held.
  assign rom_en   = (state == ISSUE);
  assign rom_addr = rom_en ? issue_addr : rom_addr_q;
  assign refl_in  = (state == REFL) ? cur : '0;
  assign busy     = (state != IDLE);

  assign shift0 = shift_r[0];
  assign shift1 = shift_r[1];
  assign shift2 = shift_r[2];
  assign type0  = type_r[0];
  assign type1  = type_r[1];
  assign type2  = type_r[2];

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cur_nxt       = cur;
    shift_nxt     = shift_r;
    type_nxt      = type_r;
    letter_nxt    = letter_out;
    out_valid_nxt = 1'b0;

    key_accept      = (state == IDLE) && key_ok && (key <= LAST_LETTER);
    key_dropped_nxt = key_ok && !key_accept;

    case (state)
      IDLE: begin
        if (key_accept) begin
          cur_nxt   = key;
          state_nxt = STEP;
        end else begin
          for (int unsigned r = 0; r < NUM_ROTORS; r++) begin
            if (inc_vec[r]) begin
              if (increase_shift_or_type) type_nxt[r]  = next_type(type_r[r]);
              else                        shift_nxt[r] = next_letter(shift_r[r]);
            end
          end
        end
      end

      // All three decisions use the pre-step positions (double-step anomaly).
      STEP: begin
        shift_nxt[0] = next_letter(shift_r[0]);
        if ((shift_r[0] == NOTCH) || (shift_r[1] == NOTCH)) shift_nxt[1] = next_letter(shift_r[1]);
        if (shift_r[1] == NOTCH) shift_nxt[2] = next_letter(shift_r[2]);
        idx_nxt   = '0;
        state_nxt = ISSUE;
      end

      ISSUE: state_nxt = CAPTURE;

      CAPTURE: begin
        cur_nxt = exit_letter;
        if (idx == IDX_LAST_FWD) begin
          idx_nxt   = idx + 3'd1;
          state_nxt = REFL;
        end else if (idx == IDX_LAST) begin
          idx_nxt   = '0;
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 3'd1;
          state_nxt = ISSUE;
        end
      end

      REFL: begin
        cur_nxt   = refl_out;
        state_nxt = ISSUE;
      end

      DONE: begin
        letter_nxt    = cur;
        out_valid_nxt = 1'b1;
        state_nxt     = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      cur         <= '0;
      shift_r     <= '{default: '0};
      type_r      <= '{default: '0};
      letter_out  <= '0;
      out_valid   <= 1'b0;
      key_dropped <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cur         <= cur_nxt;
      shift_r     <= shift_nxt;
      type_r      <= type_nxt;
      letter_out  <= letter_nxt;
      out_valid   <= out_valid_nxt;
      key_dropped <= key_dropped_nxt;
      rom_addr_q  <= rom_addr;
    end
  end

endmodule
